// File: rtl/suit_pkg.sv
// Shared types and constants for the suit classifier: suit codes, FSM states, score width.
package suit_pkg;

  localparam int SCORE_W   = 10;
  localparam int NUM_SUITS = 4;

  typedef enum logic [1:0] {
    SPADE   = 2'd0,
    HEART   = 2'd1,
    DIAMOND = 2'd2,
    CLUB    = 2'd3
  } suit_t;

  typedef enum logic [1:0] {
    ST_COLLECT = 2'd0,
    ST_COMPARE = 2'd1,
    ST_EMIT    = 2'd2
  } state_t;

endpackage

// File: rtl/suit_classifier_if.sv
// Scorer-to-classifier bundle: four per-suit scores with done pulses, and the decision outputs.
interface suit_classifier_if;
  import suit_pkg::*;

  logic [SCORE_W-1:0] spade_score;
  logic [SCORE_W-1:0] heart_score;
  logic [SCORE_W-1:0] diamond_score;
  logic [SCORE_W-1:0] club_score;
  logic [3:0]         score_valid;

  logic [1:0]         suit;
  logic               suit_valid;
  logic               suit_reject;
  logic [SCORE_W-1:0] best_score;
  logic [SCORE_W-1:0] margin;
  logic               busy;
  logic               overrun;

  modport master (
    output spade_score, heart_score, diamond_score, club_score, score_valid,
    input  suit, suit_valid, suit_reject, best_score, margin, busy, overrun
  );

  modport slave (
    input  spade_score, heart_score, diamond_score, club_score, score_valid,
    output suit, suit_valid, suit_reject, best_score, margin, busy, overrun
  );

endinterface

// File: rtl/score_rank_step.sv
// One best/second-best update against a candidate score; strict less-than keeps the earlier index on ties.
module score_rank_step
  import suit_pkg::*;
(
  input  logic [SCORE_W-1:0] best_in,
  input  logic [SCORE_W-1:0] second_in,
  input  logic [1:0]         best_idx_in,
  input  logic [SCORE_W-1:0] cand,
  input  logic [1:0]         cand_idx,
  output logic [SCORE_W-1:0] best_out,
  output logic [SCORE_W-1:0] second_out,
  output logic [1:0]         best_idx_out
);

  always_comb begin
    best_out     = best_in;
    second_out   = second_in;
    best_idx_out = best_idx_in;
    if (cand < best_in) begin
      best_out     = cand;
      second_out   = best_in;
      best_idx_out = cand_idx;
    end else if (cand < second_in) begin
      second_out   = cand;
    end
  end

endmodule

// File: rtl/suit_classifier.sv
// Collects four per-suit mismatch scores, ranks them over four compare cycles and emits one suit decision.
// Optional collection timeout is enabled by defining SUIT_TIMEOUT_EN.
module suit_classifier
  import suit_pkg::*;
#(
  parameter int REJECT_THRESH = 300,
  parameter int MIN_MARGIN    = 40
`ifdef SUIT_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC   = 4096
`endif
)
(
  input  logic               clk,
  input  logic               rst_n,
  suit_classifier_if.slave   bus
);

  localparam logic [SCORE_W-1:0] REJ_T    = SCORE_W'(REJECT_THRESH);
  localparam logic [SCORE_W-1:0] MARGIN_T = SCORE_W'(MIN_MARGIN);

  state_t             state_reg;
  logic [3:0]         got_reg;
  logic [3:0]         got_next;
  logic               all_in;
  logic               tmo_fire;
  logic               timed_out_reg;
  logic [1:0]         cmp_idx_reg;
  logic [SCORE_W-1:0] score_reg [NUM_SUITS];
  logic [SCORE_W-1:0] in_score  [NUM_SUITS];

  logic [SCORE_W-1:0] best_reg;
  logic [SCORE_W-1:0] second_reg;
  logic [1:0]         best_idx_reg;

  logic [SCORE_W-1:0] step_best_in;
  logic [SCORE_W-1:0] step_second_in;
  logic [1:0]         step_idx_in;
  logic [SCORE_W-1:0] step_best;
  logic [SCORE_W-1:0] step_second;
  logic [1:0]         step_idx;

  logic [1:0]         suit_reg;
  logic               suit_valid_reg;
  logic               suit_reject_reg;
  logic [SCORE_W-1:0] best_score_reg;
  logic [SCORE_W-1:0] margin_reg;
  logic               busy_reg;
  logic               overrun_reg;
  logic [SCORE_W-1:0] margin_calc;

  assign in_score[SPADE]   = bus.spade_score;
  assign in_score[HEART]   = bus.heart_score;
  assign in_score[DIAMOND] = bus.diamond_score;
  assign in_score[CLUB]    = bus.club_score;

  assign got_next    = got_reg | bus.score_valid;
  assign all_in      = &got_next;
  assign margin_calc = second_reg - best_reg;

`ifdef SUIT_TIMEOUT_EN
  localparam int                 TMO_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0]   TMO_MAX = TMO_W'(TIMEOUT_CYC);

  logic             tmo_run_reg;
  logic [TMO_W-1:0] tmo_cnt_reg;

  assign tmo_fire = (state_reg == ST_COLLECT) && tmo_run_reg &&
                    (tmo_cnt_reg == TMO_MAX) && !all_in;

  // Counter arms on the first pulse of a collection and is cleared whenever COLLECT is left.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_run_reg <= 1'b0;
      tmo_cnt_reg <= '0;
    end else if (state_reg != ST_COLLECT || all_in || tmo_fire) begin
      tmo_run_reg <= 1'b0;
      tmo_cnt_reg <= '0;
    end else if (tmo_run_reg) begin
      tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
    end else if (|bus.score_valid) begin
      tmo_run_reg <= 1'b1;
      tmo_cnt_reg <= TMO_W'(1);
    end
  end
`else
  assign tmo_fire = 1'b0;
`endif

  // Index 0 starts from an all-ones best/second so every real score is ranked against a clean slate.
  assign step_best_in   = (cmp_idx_reg == 2'd0) ? '1    : best_reg;
  assign step_second_in = (cmp_idx_reg == 2'd0) ? '1    : second_reg;
  assign step_idx_in    = (cmp_idx_reg == 2'd0) ? 2'd0  : best_idx_reg;

  score_rank_step u_rank (
    .best_in      (step_best_in),
    .second_in    (step_second_in),
    .best_idx_in  (step_idx_in),
    .cand         (score_reg[cmp_idx_reg]),
    .cand_idx     (cmp_idx_reg),
    .best_out     (step_best),
    .second_out   (step_second),
    .best_idx_out (step_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ST_COLLECT;
      got_reg         <= '0;
      timed_out_reg   <= 1'b0;
      cmp_idx_reg     <= '0;
      best_reg        <= '0;
      second_reg      <= '0;
      best_idx_reg    <= '0;
      suit_reg        <= '0;
      suit_valid_reg  <= 1'b0;
      suit_reject_reg <= 1'b0;
      best_score_reg  <= '0;
      margin_reg      <= '0;
      busy_reg        <= 1'b0;
      overrun_reg     <= 1'b0;
      for (int i = 0; i < NUM_SUITS; i++) begin
        score_reg[i] <= '0;
      end
    end else begin
      suit_valid_reg <= 1'b0;
      if (state_reg != ST_COLLECT && |bus.score_valid) begin
        overrun_reg <= 1'b1;
      end

      case (state_reg)
        ST_COLLECT: begin
          // Missing suits are forced to all-ones on timeout so they can never win.
          for (int i = 0; i < NUM_SUITS; i++) begin
            if (bus.score_valid[i]) begin
              score_reg[i] <= in_score[i];
            end else if (tmo_fire && !got_reg[i]) begin
              score_reg[i] <= '1;
            end
          end
          got_reg <= got_next;
          if (all_in || tmo_fire) begin
            state_reg     <= ST_COMPARE;
            timed_out_reg <= tmo_fire;
            cmp_idx_reg   <= 2'd0;
            busy_reg      <= 1'b1;
          end
        end

        ST_COMPARE: begin
          best_reg     <= step_best;
          second_reg   <= step_second;
          best_idx_reg <= step_idx;
          cmp_idx_reg  <= cmp_idx_reg + 2'd1;
          if (cmp_idx_reg == 2'd3) begin
            state_reg <= ST_EMIT;
          end
        end

        ST_EMIT: begin
          suit_reg        <= best_idx_reg;
          best_score_reg  <= best_reg;
          margin_reg      <= margin_calc;
          suit_reject_reg <= (best_reg > REJ_T) || (margin_calc < MARGIN_T) || timed_out_reg;
          suit_valid_reg  <= 1'b1;
          got_reg         <= '0;
          timed_out_reg   <= 1'b0;
          busy_reg        <= 1'b0;
          state_reg       <= ST_COLLECT;
        end

        default: begin
          state_reg <= ST_COLLECT;
          got_reg   <= '0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.suit        = suit_reg;
  assign bus.suit_valid  = suit_valid_reg;
  assign bus.suit_reject = suit_reject_reg;
  assign bus.best_score  = best_score_reg;
  assign bus.margin      = margin_reg;
  assign bus.busy        = busy_reg;
  assign bus.overrun     = overrun_reg;

endmodule

// File: tb/tb_suit_classifier.sv
// Directed bench for suit_classifier; the timeout case is built only when SUIT_TIMEOUT_EN is defined.
module tb_suit_classifier;
  import suit_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  suit_classifier_if bus();

`ifdef SUIT_TIMEOUT_EN
  suit_classifier #(.REJECT_THRESH(300), .MIN_MARGIN(40), .TIMEOUT_CYC(16)) dut (
`else
  suit_classifier #(.REJECT_THRESH(300), .MIN_MARGIN(40)) dut (
`endif
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [3:0] v, input int s0, input int s1, input int s2, input int s3);
    @(negedge clk);
    bus.score_valid   = v;
    bus.spade_score   = SCORE_W'(s0);
    bus.heart_score   = SCORE_W'(s1);
    bus.diamond_score = SCORE_W'(s2);
    bus.club_score    = SCORE_W'(s3);
  endtask

  task automatic release_valid();
    @(negedge clk);
    bus.score_valid = 4'b0000;
  endtask

  task automatic count_pulses(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (bus.suit_valid) n++;
    end
  endtask

  // exp_lat < 0 skips the latency comparison (timeout case).
  task automatic expect_decision(input string tag, input int exp_lat, input int e_suit,
                                 input int e_best, input int e_margin, input int e_rej);
    int  n;
    bit  seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 64) begin
      @(posedge clk); #1;
      n++;
      if (bus.suit_valid) seen = 1'b1;
    end
    $display("txn %s: seen=%0d lat=%0d suit=%0d best=%0d margin=%0d reject=%0d overrun=%0d",
             tag, seen, n, bus.suit, bus.best_score, bus.margin, bus.suit_reject, bus.overrun);
    check({tag, "_seen"}, 32'(seen), 32'd1);
    if (exp_lat >= 0) check({tag, "_lat"}, n, exp_lat);
    check({tag, "_suit"},   32'(bus.suit),        e_suit);
    check({tag, "_best"},   32'(bus.best_score),  e_best);
    check({tag, "_margin"}, 32'(bus.margin),      e_margin);
    check({tag, "_reject"}, 32'(bus.suit_reject), e_rej);
  endtask

  initial begin
    int n;
    rst_n             = 1'b0;
    bus.score_valid   = 4'b0000;
    bus.spade_score   = '0;
    bus.heart_score   = '0;
    bus.diamond_score = '0;
    bus.club_score    = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_suit",       32'(bus.suit),        0);
    check("rst_valid",      32'(bus.suit_valid),  0);
    check("rst_reject",     32'(bus.suit_reject), 0);
    check("rst_best",       32'(bus.best_score),  0);
    check("rst_margin",     32'(bus.margin),      0);
    check("rst_busy",       32'(bus.busy),        0);
    check("rst_overrun",    32'(bus.overrun),     0);
    rst_n = 1'b1;

    // All four together: heart wins 120, second 450.
    drive(4'b1111, 500, 120, 480, 450);
    release_valid();
    expect_decision("all_at_once", 5, HEART, 120, 330, 0);

    // Next collection begins right after the pulse; club first then one per cycle.
    drive(4'b1000, 0, 0, 0, 90);
    @(posedge clk); #1;
    check("pulse_one_cycle", 32'(bus.suit_valid), 0);
    check("held_suit",       32'(bus.suit),       HEART);
    drive(4'b0001, 400, 0, 0, 0);
    drive(4'b0010, 0, 95, 0, 0);
    drive(4'b0100, 0, 0, 600, 0);
    release_valid();
    expect_decision("serial_club", 5, CLUB, 90, 5, 1);

    drive(4'b1111, 200, 200, 200, 200);
    release_valid();
    expect_decision("all_tie", 5, SPADE, 200, 0, 1);

    drive(4'b1111, 400, 80, 400, 80);
    release_valid();
    expect_decision("heart_club_tie", 5, HEART, 80, 0, 1);

    // Spade repeated: latest value (50) must win.
    drive(4'b0001, 700, 0, 0, 0);
    drive(4'b0001, 50, 0, 0, 0);
    drive(4'b1110, 0, 300, 300, 300);
    release_valid();
    expect_decision("spade_repeat", 5, SPADE, 50, 250, 0);

    // Pulse during COMPARE must be dropped and flag overrun.
    check("overrun_before", 32'(bus.overrun), 0);
    drive(4'b1111, 500, 120, 480, 450);
    release_valid();
    @(posedge clk); #1;
    check("busy_in_compare", 32'(bus.busy), 1);
    drive(4'b1111, 0, 0, 0, 0);
    release_valid();
    expect_decision("overrun_txn", 3, HEART, 120, 330, 0);
    check("overrun_set", 32'(bus.overrun), 1);
    @(posedge clk); #1;
    check("busy_after_emit", 32'(bus.busy), 0);
    check("overrun_sticky",  32'(bus.overrun), 1);

    // Reset mid-COMPARE: outputs clear immediately and no decision follows.
    drive(4'b1111, 10, 20, 30, 40);
    release_valid();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_suit",    32'(bus.suit),        0);
    check("midrst_valid",   32'(bus.suit_valid),  0);
    check("midrst_reject",  32'(bus.suit_reject), 0);
    check("midrst_best",    32'(bus.best_score),  0);
    check("midrst_margin",  32'(bus.margin),      0);
    check("midrst_busy",    32'(bus.busy),        0);
    check("midrst_overrun", 32'(bus.overrun),     0);
    @(negedge clk);
    rst_n = 1'b1;
    count_pulses(10, n);
    $display("txn reset_abort: pulses=%0d", n);
    check("midrst_no_pulse", n, 0);

    // Three scores only: must keep waiting, then complete on the fourth.
    drive(4'b0111, 100, 200, 300, 0);
    release_valid();
    count_pulses(10, n);
    $display("txn partial: pulses=%0d", n);
    check("partial_no_pulse", n, 0);
    drive(4'b1000, 0, 0, 0, 350);
    release_valid();
    expect_decision("partial_done", 5, SPADE, 100, 100, 0);

`ifdef SUIT_TIMEOUT_EN
    drive(4'b0100, 0, 0, 60, 0);
    release_valid();
    expect_decision("timeout", -1, DIAMOND, 60, 963, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/suit_classifier.md
# suit_classifier

Downstream stage of the four per-suit XOR scoring blocks (spade, heart, diamond, club). Each scorer reports a mismatch count over the 28×29 suit corner. This block collects the four counts for one card and ranks them over four sequential compare cycles. It emits a single suit decision with best score, margin and a reject flag, consumed by the card-identity logic.

## Interface
- `SCORE_W`, 10, width of each mismatch score; ceil(log2(812)).
- `REJECT_THRESH`, 300, a best score strictly greater than this sets reject.
- `MIN_MARGIN`, 40, a margin (second-best minus best) strictly less than this sets reject.
- `TIMEOUT_CYC`, 4096, collection timeout in cycles; used only with the macro.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `spade_score`, `heart_score`, `diamond_score`, `club_score`  in  SCORE_W each  per-suit mismatch counts.
- `score_valid`  in  4  one-cycle done pulses from the scorers: bit0 spade, bit1 heart, bit2 diamond, bit3 club.
- `suit`  out  2  winning suit code.
- `suit_valid`  out  1  one-cycle pulse; `suit`, `best_score`, `margin` and `suit_reject` are valid in that cycle and held until the next pulse.
- `suit_reject`  out  1  decision is low-confidence or incomplete.
- `best_score`  out  SCORE_W  lowest score.
- `margin`  out  SCORE_W  second-lowest minus lowest.
- `busy`  out  1  high in COMPARE and EMIT.
- `overrun`  out  1  sticky; a valid bit was dropped while busy.

## Operation
- FSM with three states.
  - COLLECT: on each set `score_valid` bit, latch that score and set its bit in `got[3:0]`. A repeat pulse for a suit already received overwrites the score (latest wins). Several bits may arrive in the same cycle. When `got` becomes 4'b1111, including via the current cycle's bits, go to COMPARE.
  - COMPARE: exactly 4 cycles. Index i runs 0..3. Each cycle updates best/second-best from score[i].
    - Strict less-than comparison, so on ties the lower index wins. Spade beats club on equal scores.
    - With equal best scores, margin=0.
  - EMIT: 1 cycle. Register the outputs, pulse `suit_valid`, clear `got`, return to COLLECT.
- `suit_reject` = (best_score > REJECT_THRESH) | (margin < MIN_MARGIN) | timed_out.
- Arithmetic is unsigned SCORE_W. The margin cannot underflow because second-best ≥ best by construction.
- Any `score_valid` bit seen in COMPARE or EMIT is dropped and sets `overrun`. `overrun` clears only on reset.

## Timing
- Final valid sampled at edge t → COMPARE during cycles t+1..t+4 → `suit_valid` high for the cycle after edge t+5.
- Total latency: 5 cycles from the last score to the decision.
- A new collection may start in the cycle immediately after the `suit_valid` pulse.
- Reset values:
  - `suit`=0, `suit_valid`=0, `suit_reject`=0, `best_score`=0, `margin`=0, `busy`=0, `overrun`=0.
  - FSM in COLLECT, `got`=0.
- Reset asserted mid-COMPARE aborts the compare immediately. No `suit_valid` is produced and the held outputs return to their reset values.

## Configuration
- `SUIT_TIMEOUT_EN` defined:
  - A counter starts on the first valid after entering COLLECT.
  - If it reaches TIMEOUT_CYC with `got` ≠ 4'b1111, go to COMPARE with every missing score treated as all-ones and timed_out=1. `suit_reject` is then forced to 1.
  - The counter resets on entering COMPARE.
- Undefined: no counter exists, and COLLECT waits indefinitely for all four scores.

## Structure
- Package `suit_pkg` holds:
  - `suit_t` enum: SPADE=0, HEART=1, DIAMOND=2, CLUB=3.
  - The FSM state enum.
  - `SCORE_W` localparam.
- One sub-module, `score_rank_step`. It is the combinational best/second-best update:
  - inputs: the current best, second-best and best index, plus a candidate score and its index;
  - outputs: the updated triple.
- The sub-module is instantiated once and reused across the 4 COMPARE cycles.

## Test plan
- Scores 500/120/480/450 pulsed together → one pulse 5 cycles later: suit=HEART, best=120, margin=330, reject=0.
- Scores 90 (club), then 400/95/600 one per cycle → suit=CLUB, best=90, margin=5, reject=1 (margin < 40).
- All four scores 200 → suit=SPADE, margin=0, reject=1.
- Spade score pulsed twice (700 then 50) before the other three at 300 → suit=SPADE, best=50, margin=250.
- Valid pulsed during COMPARE → `overrun`=1, the decision is unaffected. Reset during COMPARE → no `suit_valid`, all outputs 0.
- With `SUIT_TIMEOUT_EN` and TIMEOUT_CYC=16: only the diamond score (60) arrives → after 16 cycles, suit=DIAMOND, best=60, reject=1.
